// File: rtl/mant_mul24_seq_if.sv
// Request/result bundle between the FP multiplication controller and the
// sequential mantissa multiplier.
//   Datain1/Datain2 : W-bit significands A and B (hidden bit included)
//   Data_valid      : request, held high by the controller until Ack is seen
//   Dataout         : 2*W-bit product A*B
//   Exc             : 3'b000 normal, 3'b001 zero operand
//   Ack             : result valid
interface mant_mul24_seq_if #(
  parameter int unsigned W = 24
);
  logic [W-1:0]   Datain1;
  logic [W-1:0]   Datain2;
  logic           Data_valid;
  logic [2*W-1:0] Dataout;
  logic [2:0]     Exc;
  logic           Ack;

  // Controller side
  modport master (
    output Datain1, Datain2, Data_valid,
    input  Dataout, Exc, Ack
  );

  // Multiplier side
  modport slave (
    input  Datain1, Datain2, Data_valid,
    output Dataout, Exc, Ack
  );
endinterface

// File: rtl/mant_mul24_seq.sv
// Sequential 24x24 unsigned mantissa multiplier, radix-2 shift-add, one
// partial product per cycle, with a zero-operand shortcut.
//   CLK  : clock, rising edge
//   RSTn : synchronous active-low reset
//   bus  : slave side of mant_mul24_seq_if (operands, valid, product, Exc, Ack)
// All outputs are registered.
module mant_mul24_seq (
  input  logic             CLK,
  input  logic             RSTn,
  mant_mul24_seq_if.slave  bus
);

  localparam int unsigned W  = 24;
  localparam int unsigned PW = 2 * W;
  localparam int unsigned CW = $clog2(W);

  localparam logic [2:0] EXC_NORMAL = 3'b000;
  localparam logic [2:0] EXC_ZERO   = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_mcand;
  logic [PW-1:0]   r_p;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_dataout;
  logic [2:0]      r_exc;
  logic            r_ack;

  logic [W:0]      w_sum;
  logic [PW-1:0]   w_p_shift;

  // Partial-product add; the carry out is kept in w_sum[W] and shifted into
  // bit PW-1, so the extra accumulator bit above it is always zero and is
  // not stored.
  assign w_sum     = {1'b0, r_p[PW-1:W]} + (r_p[0] ? {1'b0, r_mcand} : (W+1)'(0));
  assign w_p_shift = {w_sum, r_p[W-1:1]};

  // Control FSM and datapath
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_p       <= '0;
      r_cnt     <= '0;
      r_dataout <= '0;
      r_exc     <= EXC_NORMAL;
      r_ack     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.Data_valid) begin
            r_mcand <= bus.Datain1;
            r_p     <= {W'(0), bus.Datain2};
            r_cnt   <= '0;
            if ((bus.Datain1 == W'(0)) || (bus.Datain2 == W'(0))) begin
              r_dataout <= '0;
              r_exc     <= EXC_ZERO;
              r_state   <= S_DONE;
            end else begin
              r_exc   <= EXC_NORMAL;
              r_state <= S_BUSY;
            end
          end
        end

        S_BUSY: begin
          r_p   <= w_p_shift;
          r_cnt <= CW'(r_cnt + CW'(1));
          if (r_cnt == CW'(W - 1)) begin
            r_dataout <= w_p_shift;
            r_state   <= S_DONE;
          end
        end

        S_DONE: begin
          // Ack always rises once on entry, so a request dropped during BUSY
          // still gets a single-cycle Ack pulse.
          if (!r_ack) begin
            r_ack <= 1'b1;
          end else if (!bus.Data_valid) begin
            r_ack   <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Dataout = r_dataout;
  assign bus.Exc     = r_exc;
  assign bus.Ack     = r_ack;

endmodule

// File: tb/tb_mant_mul24_seq.sv
// Self-checking bench for mant_mul24_seq: directed corner cases plus
// randomized transactions against an arithmetic reference model.
module tb_mant_mul24_seq;

  localparam int unsigned W = 24;

  logic CLK;
  logic RSTn;
  int   n_total;
  int   n_bad;

  mant_mul24_seq_if #(.W(W)) bus ();

  mant_mul24_seq dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: full unsigned product, zero operand flagged, latency 1 or W+1.
  function automatic logic [63:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned pa, pb;
    pa = longint'(a);
    pb = longint'(b);
    return 64'(pa * pb);
  endfunction

  // One transaction: accept, optional drop of valid during BUSY with operand
  // toggling, wait for Ack, hold valid for 'hold' cycles, then release.
  task automatic do_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input int drop_after);
    logic [63:0] exp_p;
    logic [2:0]  exp_exc;
    int          exp_lat;
    int          lat;
    bit          got;
    bit          dropped;
    exp_p   = ref_prod(a, b);
    exp_exc = ((a == '0) || (b == '0)) ? 3'b001 : 3'b000;
    exp_lat = (exp_exc == 3'b001) ? 1 : W + 1;
    dropped = 1'b0;

    @(negedge CLK);
    bus.Datain1    = a;
    bus.Datain2    = b;
    bus.Data_valid = 1'b1;
    @(posedge CLK);               // accepting edge
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
      if (drop_after > 0 && lat == drop_after) begin
        bus.Data_valid = 1'b0;
        dropped = 1'b1;
      end
      if (dropped) begin
        bus.Datain1 = W'($urandom);
        bus.Datain2 = W'($urandom);
      end
      if (bus.Ack) begin
        got = 1'b1;
        break;
      end
    end
    chk("ack_seen", 64'(got), 64'd1);
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("product", 64'(bus.Dataout), exp_p);
    chk("exc", 64'(bus.Exc), 64'(exp_exc));

    if (dropped) begin
      @(negedge CLK);
      chk("pulse_ack_low", 64'(bus.Ack), 64'd0);
    end else begin
      for (int i = 0; i < hold; i++) begin
        @(negedge CLK);
        chk("hold_ack", 64'(bus.Ack), 64'd1);
        chk("hold_product", 64'(bus.Dataout), exp_p);
      end
      bus.Data_valid = 1'b0;
      @(negedge CLK);
      chk("ack_fall", 64'(bus.Ack), 64'd0);
      chk("post_product", 64'(bus.Dataout), exp_p);
    end
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    n_total        = 0;
    n_bad          = 0;
    RSTn           = 1'b0;
    bus.Datain1    = '0;
    bus.Datain2    = '0;
    bus.Data_valid = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ack", 64'(bus.Ack), 64'd0);
    chk("rst_dataout", 64'(bus.Dataout), 64'd0);
    chk("rst_exc", 64'(bus.Exc), 64'd0);
    RSTn = 1'b1;

    // Directed corner cases
    do_txn(24'hFFFFFF, 24'hFFFFFF, 0, 0);
    do_txn(24'h800000, 24'h800000, 0, 0);
    do_txn(24'hC00000, 24'hA00000, 0, 0);
    do_txn(24'h000000, 24'hABCDEF, 0, 0);
    do_txn(24'hABCDEF, 24'h000000, 1, 0);
    do_txn(24'h7FFFFF, 24'h000001, 10, 0);
    do_txn(24'h000003, 24'h000005, 0, 0);

    // Reset during BUSY cycle 12 abandons the computation
    @(negedge CLK);
    bus.Datain1    = 24'hFEDCBA;
    bus.Datain2    = 24'h987654;
    bus.Data_valid = 1'b1;
    @(posedge CLK);
    repeat (12) @(posedge CLK);
    @(negedge CLK);
    RSTn           = 1'b0;
    bus.Data_valid = 1'b0;
    @(negedge CLK);
    RSTn = 1'b1;
    chk("midrst_ack", 64'(bus.Ack), 64'd0);
    chk("midrst_dataout", 64'(bus.Dataout), 64'd0);
    chk("midrst_exc", 64'(bus.Exc), 64'd0);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
        @(negedge CLK);
        if (bus.Ack) seen = 1'b1;
      end
      chk("midrst_no_ack", 64'(seen), 64'd0);
    end
    do_txn(24'h123456, 24'h000002, 0, 0);

    // Valid dropped during BUSY while operands toggle
    do_txn(24'h9ABCDE, 24'hF0F0F1, 0, 5);
    do_txn(24'h000000, 24'h123456, 0, 1);

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      a = W'($urandom);
      b = W'($urandom);
      if ($urandom_range(0, 9) == 0) a = '0;
      if ($urandom_range(0, 9) == 0) b = '0;
      if ($urandom_range(0, 3) == 0) a[W-1] = 1'b1;
      do_txn(a, b, int'($urandom_range(0, 3)),
             ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 20)) : 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
